// File: rtl/ahb5_slave_pkg.sv
// ahb5_slave_pkg: shared AHB5 encodings, responder FSM states and transfer helpers.
// ERR1/ERR2 states exist only when AHB5_SLV_ERR_RESP_EN is defined.
package ahb5_slave_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
`ifdef AHB5_SLV_ERR_RESP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT} state_t;
`endif
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        byte_en = size == HSIZE_WORD ? 4'hf : size == HSIZE_HALF ? (lane[1] ? 4'hc : 4'h3) : 4'b0001 << lane;
    endfunction
    function automatic logic xfer_err(input logic [31:0] addr, input logic [2:0] size, input int depth);
        xfer_err = ({2'b00, addr[31:2]} >= $unsigned(depth)) || (size > HSIZE_WORD) ||
                   (size == HSIZE_HALF && addr[0]) || (size == HSIZE_WORD && addr[1:0] != 2'b00);
    endfunction
endpackage

// File: rtl/ahb5_slave_mem.sv
// ahb5_slave_mem: word array with per-byte write enables and asynchronous read.
module ahb5_slave_mem #(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/ahb5_slave_mem_responder.sv
// ahb5_slave_mem_responder: AHB5 memory slave with fixed wait states per data phase.
// Define AHB5_SLV_ERR_RESP_EN for the two-cycle ERROR response; otherwise bad transfers complete OKAY and are dropped.
module ahb5_slave_mem_responder import ahb5_slave_pkg::*; #(
    parameter int MEM_DEPTH = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        Hclk,
    input  logic        HRESET,
    input  logic        Hsel,
    input  logic [31:0] Haddr,
    input  logic [1:0]  Htrans,
    input  logic        Hwrite,
    input  logic [2:0]  Hsize,
    input  logic        Hready,
    input  logic [31:0] Hwdata,
    output logic        Hreadyout,
    output logic        Hresp,
    output logic [31:0] Hrdata
);
    localparam int AW = $clog2(MEM_DEPTH);
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic dp_valid, dp_err, dp_write, cap, err, we;
    logic [AW-1:0] dp_idx;
    logic [1:0] dp_lane;
    logic [2:0] dp_size;
    logic [31:0] mem_rdata;

    // A new address phase is only sampled while this slave is not stalling the bus
    assign cap = Hsel && Hready && Hreadyout && Htrans[1];
    assign err = xfer_err(Haddr, Hsize, MEM_DEPTH);

    always_ff @(posedge Hclk) begin
        if (HRESET) begin
            state <= ST_IDLE;
            cnt <= '0;
            dp_valid <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (Hreadyout) begin
                dp_valid <= cap;
                dp_err <= err;
                dp_write <= Hwrite;
                dp_idx <= Haddr[AW+1:2];
                dp_lane <= Haddr[1:0];
                dp_size <= Hsize;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        Hreadyout = 1'b1;
        Hresp = HRESP_OKAY;
        if (state == ST_WAIT) begin
            Hreadyout = 1'b0;
            state_nx = cnt == 4'(WAIT_STATES) ? ST_IDLE : ST_WAIT;
            cnt_nx = cnt == 4'(WAIT_STATES) ? 4'd0 : cnt + 4'd1;
        end
`ifdef AHB5_SLV_ERR_RESP_EN
        else if (state == ST_ERR1) begin
            Hreadyout = 1'b0;
            Hresp = HRESP_ERROR;
            state_nx = ST_ERR2;
        end
`endif
        else begin
`ifdef AHB5_SLV_ERR_RESP_EN
            Hresp = state == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
            state_nx = cap && err ? ST_ERR1 : cap && WAIT_STATES > 0 ? ST_WAIT : ST_IDLE;
`else
            state_nx = cap && WAIT_STATES > 0 ? ST_WAIT : ST_IDLE;
`endif
            cnt_nx = cap ? 4'd1 : 4'd0;
        end
    end

    assign we = !HRESET && Hreadyout && dp_valid && dp_write && !dp_err;
    assign Hrdata = Hreadyout && dp_valid && !dp_write && !dp_err ? mem_rdata : 32'h0;

    ahb5_slave_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
        .clk(Hclk),
        .we(we),
        .waddr(dp_idx),
        .be(byte_en(dp_size, dp_lane)),
        .wdata(Hwdata),
        .raddr(dp_idx),
        .rdata(mem_rdata)
    );
endmodule

// File: tb/tb_ahb5_slave_mem_responder.sv
// tb_ahb5_slave_mem_responder: directed checks on three responders (0, 3 and 2 wait states) sharing one bus.
module tb_ahb5_slave_mem_responder;
    import ahb5_slave_pkg::*;
    logic Hclk = 1'b0, HRESET = 1'b1, hsel = 1'b0, Hwrite = 1'b0;
    logic [31:0] Haddr = '0, Hwdata = '0;
    logic [1:0] Htrans = HTRANS_IDLE;
    logic [2:0] Hsize = HSIZE_WORD;
    int sel = 0, vecs = 0, errs = 0;
    logic rdy0, rdy1, rdy2, rsp0, rsp1, rsp2, ro, rp;
    logic [31:0] rd0, rd1, rd2, rd;

    always #5 Hclk = ~Hclk;

    ahb5_slave_mem_responder #(.MEM_DEPTH(256), .WAIT_STATES(0)) u0 (
        .Hclk(Hclk), .HRESET(HRESET), .Hsel(hsel && sel == 0), .Haddr(Haddr), .Htrans(Htrans),
        .Hwrite(Hwrite), .Hsize(Hsize), .Hready(rdy0), .Hwdata(Hwdata),
        .Hreadyout(rdy0), .Hresp(rsp0), .Hrdata(rd0));
    ahb5_slave_mem_responder #(.MEM_DEPTH(256), .WAIT_STATES(3)) u1 (
        .Hclk(Hclk), .HRESET(HRESET), .Hsel(hsel && sel == 1), .Haddr(Haddr), .Htrans(Htrans),
        .Hwrite(Hwrite), .Hsize(Hsize), .Hready(rdy1), .Hwdata(Hwdata),
        .Hreadyout(rdy1), .Hresp(rsp1), .Hrdata(rd1));
    ahb5_slave_mem_responder #(.MEM_DEPTH(256), .WAIT_STATES(2)) u2 (
        .Hclk(Hclk), .HRESET(HRESET), .Hsel(hsel && sel == 2), .Haddr(Haddr), .Htrans(Htrans),
        .Hwrite(Hwrite), .Hsize(Hsize), .Hready(rdy2), .Hwdata(Hwdata),
        .Hreadyout(rdy2), .Hresp(rsp2), .Hrdata(rd2));

    assign ro = sel == 0 ? rdy0 : sel == 1 ? rdy1 : rdy2;
    assign rp = sel == 0 ? rsp0 : sel == 1 ? rsp1 : rsp2;
    assign rd = sel == 0 ? rd0 : sel == 1 ? rd1 : rd2;

    task automatic nxt;
        @(posedge Hclk);
        #1;
    endtask

    task automatic obs;
        @(negedge Hclk);
    endtask

    task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] s);
        Htrans = t;
        Haddr = a;
        Hwrite = w;
        Hsize = s;
    endtask

    task automatic test_reset;
        HRESET = 1'b1;
        nxt;
        nxt;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            obs;
            vecs++; if (ro !== 1'b1) begin errs++; $display("FAIL reset_ready[%0d]: got %b want 1", k, ro); end
            vecs++; if (rp !== 1'b0) begin errs++; $display("FAIL reset_resp[%0d]: got %b want 0", k, rp); end
            vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rd); end
        end
        HRESET = 1'b0;
        hsel = 1'b1;
        nxt;
    endtask

    task automatic test_write_read_ws0;
        sel = 0;
        drive(HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD);
        nxt;
        Hwdata = 32'hDEADBEEF;
        drive(HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD);
        obs;
        vecs++; if (ro !== 1'b1) begin errs++; $display("FAIL ws0_wr_ready: got %b want 1", ro); end
        vecs++; if (rp !== 1'b0) begin errs++; $display("FAIL ws0_wr_resp: got %b want 0", rp); end
        nxt;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        obs;
        vecs++; if (ro !== 1'b1) begin errs++; $display("FAIL ws0_rd_ready: got %b want 1", ro); end
        vecs++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL ws0_rd_data: got %h want deadbeef", rd); end
        vecs++; if (rp !== 1'b0) begin errs++; $display("FAIL ws0_rd_resp: got %b want 0", rp); end
        nxt;
    endtask

    task automatic test_byte_lanes;
        sel = 0;
        drive(HTRANS_NONSEQ, 32'h20, 1'b1, HSIZE_WORD);
        nxt;
        Hwdata = 32'h11223344;
        drive(HTRANS_NONSEQ, 32'h21, 1'b1, HSIZE_BYTE);
        nxt;
        Hwdata = 32'h0000AA00;
        drive(HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD);
        nxt;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        obs;
        vecs++; if (rd !== 32'h1122AA44) begin errs++; $display("FAIL byte_write: got %h want 1122aa44", rd); end
        nxt;
        drive(HTRANS_NONSEQ, 32'h22, 1'b1, HSIZE_HALF);
        nxt;
        Hwdata = 32'hBEEF0000;
        drive(HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD);
        nxt;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        obs;
        vecs++; if (rd !== 32'hBEEFAA44) begin errs++; $display("FAIL half_write: got %h want beefaa44", rd); end
        nxt;
    endtask

    task automatic test_wait3;
        sel = 1;
        drive(HTRANS_NONSEQ, 32'h0, 1'b1, HSIZE_WORD);
        nxt;
        Hwdata = 32'hCAFEF00D;
        // next address phase is held on the bus and must wait for Hreadyout
        drive(HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD);
        for (int i = 0; i < 4; i++) begin
            obs;
            vecs++; if (ro !== (i == 3)) begin errs++; $display("FAIL ws3_wr_ready[%0d]: got %b want %b", i, ro, i == 3); end
            nxt;
        end
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        for (int i = 0; i < 4; i++) begin
            obs;
            vecs++; if (ro !== (i == 3)) begin errs++; $display("FAIL ws3_rd_ready[%0d]: got %b want %b", i, ro, i == 3); end
            vecs++; if (rd !== (i == 3 ? 32'hCAFEF00D : 32'h0)) begin errs++; $display("FAIL ws3_rd_data[%0d]: got %h", i, rd); end
            nxt;
        end
    endtask

    task automatic test_errors;
        logic [31:0] ea [3];
        logic [2:0] es [3];
        ea[0] = 32'h402; es[0] = HSIZE_WORD;
        ea[1] = 32'h400; es[1] = HSIZE_WORD;
        ea[2] = 32'h10;  es[2] = 3'd3;
        sel = 0;
        for (int e = 0; e < 3; e++) begin
            drive(HTRANS_NONSEQ, ea[e], 1'b0, es[e]);
            nxt;
            drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
            obs;
`ifdef AHB5_SLV_ERR_RESP_EN
            vecs++; if (ro !== 1'b0 || rp !== 1'b1) begin errs++; $display("FAIL err1[%0d]: ready=%b resp=%b want 0/1", e, ro, rp); end
            nxt;
            obs;
            vecs++; if (ro !== 1'b1 || rp !== 1'b1) begin errs++; $display("FAIL err2[%0d]: ready=%b resp=%b want 1/1", e, ro, rp); end
`else
            vecs++; if (ro !== 1'b1 || rp !== 1'b0) begin errs++; $display("FAIL err_okay[%0d]: ready=%b resp=%b want 1/0", e, ro, rp); end
`endif
            vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL err_rdata[%0d]: got %h want 0", e, rd); end
            nxt;
            obs;
            vecs++; if (ro !== 1'b1 || rp !== 1'b0) begin errs++; $display("FAIL err_after[%0d]: ready=%b resp=%b want 1/0", e, ro, rp); end
            nxt;
        end
        drive(HTRANS_NONSEQ, 32'h12, 1'b1, HSIZE_WORD);
        nxt;
        Hwdata = 32'h55555555;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        nxt;
        nxt;
        drive(HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD);
        nxt;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        obs;
        vecs++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL err_write_dropped: got %h want deadbeef", rd); end
        nxt;
    endtask

    task automatic test_reset_mid_wait;
        sel = 2;
        drive(HTRANS_NONSEQ, 32'h30, 1'b1, HSIZE_WORD);
        nxt;
        Hwdata = 32'h12345678;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        for (int i = 0; i < 3; i++) begin
            obs;
            vecs++; if (ro !== (i == 2)) begin errs++; $display("FAIL ws2_wr_ready[%0d]: got %b want %b", i, ro, i == 2); end
            nxt;
        end
        drive(HTRANS_NONSEQ, 32'h30, 1'b1, HSIZE_WORD);
        nxt;
        Hwdata = 32'hFFFFFFFF;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        obs;
        vecs++; if (ro !== 1'b0) begin errs++; $display("FAIL rst_mid_wait_stall: got %b want 0", ro); end
        HRESET = 1'b1;
        nxt;
        HRESET = 1'b0;
        obs;
        vecs++; if (ro !== 1'b1 || rp !== 1'b0) begin errs++; $display("FAIL rst_mid_wait_ready: ready=%b resp=%b want 1/0", ro, rp); end
        nxt;
        drive(HTRANS_NONSEQ, 32'h30, 1'b0, HSIZE_WORD);
        nxt;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        for (int i = 0; i < 3; i++) begin
            obs;
            vecs++; if (ro !== (i == 2)) begin errs++; $display("FAIL ws2_rd_ready[%0d]: got %b want %b", i, ro, i == 2); end
            nxt;
        end
        vecs++; if (rd2 !== 32'h0) begin errs++; $display("FAIL ws2_rdata_after: got %h want 0", rd2); end
        drive(HTRANS_NONSEQ, 32'h30, 1'b0, HSIZE_WORD);
        nxt;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        nxt;
        nxt;
        obs;
        vecs++; if (rd !== 32'h12345678) begin errs++; $display("FAIL rst_mid_wait_mem: got %h want 12345678", rd); end
        nxt;
    endtask

    task automatic test_idle_between;
        sel = 0;
        drive(HTRANS_NONSEQ, 32'h40, 1'b1, HSIZE_WORD);
        nxt;
        Hwdata = 32'hA5A50001;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        nxt;
        drive(HTRANS_NONSEQ, 32'h44, 1'b1, HSIZE_WORD);
        obs;
        vecs++; if (ro !== 1'b1 || rp !== 1'b0) begin errs++; $display("FAIL idle_phase: ready=%b resp=%b want 1/0", ro, rp); end
        nxt;
        Hwdata = 32'h5A5A0002;
        drive(HTRANS_NONSEQ, 32'h40, 1'b0, HSIZE_WORD);
        nxt;
        drive(HTRANS_NONSEQ, 32'h44, 1'b0, HSIZE_WORD);
        obs;
        vecs++; if (rd !== 32'hA5A50001) begin errs++; $display("FAIL idle_first_write: got %h want a5a50001", rd); end
        nxt;
        drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
        obs;
        vecs++; if (rd !== 32'h5A5A0002) begin errs++; $display("FAIL idle_second_write: got %h want 5a5a0002", rd); end
        nxt;
    endtask

    initial begin
        test_reset;
        test_write_read_ws0;
        test_byte_lanes;
        test_wait3;
        test_errors;
        test_reset_mid_wait;
        test_idle_between;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ahb5_slave_mem_responder.md
AHB5_SLAVE_MEM_RESPONDER -- requirements
Module: ahb5_slave_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning number of 32-bit words of backing storage (power of 2).
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning data-phase wait cycles per transfer (0..15).
REQ-003 SHALL have port Hclk  input  1  single bus clock; all logic on posedge.
REQ-004 SHALL have port HRESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Hsel  input  1  slave select.
REQ-006 SHALL have port Haddr  input  32  byte address.
REQ-007 SHALL have port Htrans  input  2  IDLE/BUSY/NONSEQ/SEQ.
REQ-008 SHALL have port Hwrite  input  1  1=write.
REQ-009 SHALL have port Hsize  input  3  transfer size (0=byte, 1=half, 2=word).
REQ-010 SHALL have port Hready  input  1  bus-level ready (previous transfer done).
REQ-011 SHALL have port Hwdata  input  32  write data, data phase.
REQ-012 SHALL have port Hreadyout  output  1  slave ready.
REQ-013 SHALL have port Hresp  output  1  0=OKAY, 1=ERROR.
REQ-014 SHALL have port Hrdata  output  32  read data, data phase.

Function
REQ-015 SHALL capture an address phase on posedge when Hsel && Hready && Htrans[1]; captured: word index, Haddr[1:0], Hsize, Hwrite.
REQ-016 SHALL treat IDLE/BUSY, or Hsel=0, as no transfer: next data phase Hreadyout=1, Hresp=0.
REQ-017 SHALL use FSM states IDLE, WAIT, ERR1, ERR2; IDLE->WAIT on valid capture with WAIT_STATES>0; WAIT->IDLE when wait counter reaches WAIT_STATES.
REQ-018 SHALL hold Hreadyout=0 for exactly WAIT_STATES cycles of each valid data phase, then drive Hreadyout=1 for one cycle.
REQ-019 SHALL commit write data on the posedge ending the data phase (Hreadyout=1), byte lanes per Hsize/Haddr[1:0], little-endian; other bytes unchanged.
REQ-020 SHALL drive Hrdata with the full addressed word when Hreadyout=1 in a read data phase, otherwise 0.
REQ-021 SHALL flag an error for: word index >= MEM_DEPTH, Hsize > 2, or misalignment (half with Haddr[0]=1, word with Haddr[1:0]!=0).
REQ-022 SHALL respond to an errored transfer with two-cycle ERROR: ERR1 (Hreadyout=0, Hresp=1), ERR2 (Hreadyout=1, Hresp=1), no memory update, no wait states.
REQ-023 SHALL accept a new address phase in the same cycle Hreadyout=1 ends the previous data phase (back-to-back, pipelined).
REQ-024 SHALL return the newly written value to a read of the same address issued directly after a write.
REQ-025 SHALL ignore Htrans/Haddr while Hreadyout=0 (Hready low at bus level).

Reset
REQ-026 SHALL, with HRESET=1 at posedge, set FSM=IDLE, wait counter=0, Hreadyout=1, Hresp=0, Hrdata=0, and drop any in-flight transfer without writing memory.
REQ-027 SHALL NOT clear memory contents on reset.

Configuration
REQ-028 SHALL compile the error response only when macro AHB5_SLV_ERR_RESP_EN is defined.
REQ-029 SHALL, without AHB5_SLV_ERR_RESP_EN, complete errored transfers as OKAY with normal wait states, drop writes, and return Hrdata=0 for reads; ERR1/ERR2 are absent.

Structure
REQ-030 SHALL place Htrans encodings, Hsize encodings, Hresp encodings and the FSM state enum in shared package ahb5_slave_pkg.
REQ-031 SHALL implement storage as sub-module ahb5_slave_mem (word array, byte-enable write, async read).

Verification
REQ-032 SHALL cover: WAIT_STATES=0, word write 0xDEADBEEF @0x10 then read @0x10 -> Hreadyout=1 each data phase, Hrdata=0xDEADBEEF, Hresp=0.
REQ-033 SHALL cover: WAIT_STATES=3, word read @0x0 -> Hreadyout low 3 cycles, high on 4th with data.
REQ-034 SHALL cover: byte write 0xAA @0x21 onto word 0x11223344 @0x20 -> read @0x20 returns 0x1122AA44.
REQ-035 SHALL cover: with AHB5_SLV_ERR_RESP_EN, word read @0x402 (misaligned) -> Hresp=1 two cycles, Hreadyout 0 then 1; without the macro -> OKAY, Hrdata=0.
REQ-036 SHALL cover: WAIT_STATES=2, HRESET asserted mid-WAIT of write @0x30 -> Hreadyout=1 next cycle, word @0x30 unchanged.
REQ-037 SHALL cover: IDLE transfer between two NONSEQ writes -> zero-wait OKAY for the IDLE, both writes committed.
